// File: rtl/io_stress_test_sequencer.sv
// io_stress_test_sequencer: runs clear/sync/run phases of a per-link pin-stress test and
// accumulates saturating per-link error counts into a pass/fail verdict.
module io_stress_test_sequencer #(
  parameter int NUM_LINKS    = 4,
  parameter int CNT_W        = 16,
  parameter int RUN_W        = 32,
  parameter int SYNC_TIMEOUT = 1024,
  parameter int CLR_CYCLES   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_LINKS-1:0]       link_en,
  input  logic [RUN_W-1:0]           run_cycles,
  input  logic [NUM_LINKS-1:0]       chk_lock,
  input  logic [NUM_LINKS-1:0]       chk_err,
  output logic                       gen_en,
  output logic [NUM_LINKS-1:0]       chk_en,
  output logic                       chk_clear,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail_timeout,
  output logic [NUM_LINKS-1:0]       err_mask,
  output logic [NUM_LINKS*CNT_W-1:0] err_cnt
);
  typedef enum logic [2:0] {IDLE, CLEAR, SYNC, RUN, DONE, FAIL} state_t;
  state_t               state, nxt;
  logic [RUN_W-1:0]     tmr, run_lat;
  logic [NUM_LINKS-1:0] en_lat, lock_q, hit, mask_d;
  logic                 accept, locked;
  // One phase timer is shared by CLEAR, SYNC and RUN; it restarts on every state change.
  always_comb begin
    accept = state inside {IDLE, DONE, FAIL} && start && !abort && |link_en;
    locked = (chk_lock & en_lat) == en_lat;
    hit    = (state == RUN && !abort) ? en_lat & (chk_err | (lock_q & ~chk_lock)) : '0;
    mask_d = accept ? '0 : err_mask | hit;
    nxt    = abort ? IDLE : accept ? CLEAR :
             (state == CLEAR && tmr == RUN_W'(CLR_CYCLES - 1)) ? SYNC :
             (state == SYNC && locked) ? RUN :
             (state == SYNC && tmr == RUN_W'(SYNC_TIMEOUT - 1)) ? FAIL :
             (state == RUN && run_lat != '0 && tmr == run_lat - 1'b1) ? DONE : state;
  end
  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tmr          <= '0;
      run_lat      <= '0;
      en_lat       <= '0;
      lock_q       <= '0;
      gen_en       <= 1'b0;
      chk_en       <= '0;
      chk_clear    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_timeout <= 1'b0;
      err_mask     <= '0;
      err_cnt      <= '0;
    end else begin
      state        <= nxt;
      tmr          <= (nxt == state && nxt inside {CLEAR, SYNC, RUN}) ? tmr + 1'b1 : '0;
      if (accept) begin
        en_lat  <= link_en;
        run_lat <= run_cycles;
      end
      lock_q       <= chk_lock;
      gen_en       <= nxt inside {SYNC, RUN};
      chk_en       <= (nxt == RUN) ? en_lat : '0;
      chk_clear    <= nxt == CLEAR;
      busy         <= nxt inside {CLEAR, SYNC, RUN};
      done         <= nxt == DONE;
      pass         <= nxt == DONE && ~|mask_d;
      fail_timeout <= nxt == FAIL;
      err_mask     <= mask_d;
      for (int i = 0; i < NUM_LINKS; i++)
        if (accept) err_cnt[i*CNT_W +: CNT_W] <= '0;
        else if (hit[i] && ~&err_cnt[i*CNT_W +: CNT_W])
          err_cnt[i*CNT_W +: CNT_W] <= err_cnt[i*CNT_W +: CNT_W] + 1'b1;
    end
  end
endmodule
